// File: rtl/reset_sequencer.sv
// Staged reset controller: synchronises and debounces an external request, stretches
// every reset event to a minimum hold, then releases the channels in order.
module reset_sequencer #(
  parameter int N_CH            = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rst_req_async,
  input  logic            sw_rst,
  output logic [N_CH-1:0] rst_out,
  output logic            ready,
  output logic [1:0]      cause
);

  localparam int MAX_HG = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int MAX_C  = (MAX_HG > DEBOUNCE_CYCLES) ? MAX_HG : DEBOUNCE_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam int IW     = $clog2(N_CH + 1);

  localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]   GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0]   DB_MAX    = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [IW-1:0]   IDX_ONE   = IW'(1);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(N_CH - 1);
  localparam logic [IW-1:0]   IDX_END   = IW'(N_CH);
  localparam logic [N_CH-1:0] ALL_ONES  = '1;
  localparam logic            SINGLE_CH = (N_CH == 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          db_cnt_q, db_cnt_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [N_CH-1:0]        rst_out_q, rst_out_d;
  logic                   ready_q, ready_d;
  logic [1:0]             cause_q, cause_d;

  logic req_sync_s;
  logic req_active_s;
  logic event_s;

  assign req_sync_s   = sync_q[SYNC_STAGES-1];
  assign req_active_s = (db_cnt_q == DB_MAX);
  assign event_s      = req_active_s | sw_rst;

  // synchroniser shift and saturating debounce counter
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rst_req_async};
    if (!req_sync_s) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_MAX) begin
      db_cnt_d = db_cnt_q;
    end else begin
      db_cnt_d = db_cnt_q + CNT_ONE;
    end
  end

  // sequencing FSM next-state; any reset event forces a full restart of the hold
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    cause_d   = cause_q;
    if (event_s) begin
      state_d   = ST_ASSERT;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = ALL_ONES;
      ready_d   = 1'b0;
      cause_d   = req_active_s ? 2'b01 : 2'b10;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          rst_out_d = ALL_ONES;
          if (cnt_q == HOLD_LAST) begin
            cnt_d     = '0;
            idx_d     = IDX_ONE;
            rst_out_d = ALL_ONES << 1;
            state_d   = SINGLE_CH ? ST_RUN : ST_RELEASE;
            ready_d   = SINGLE_CH;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (idx_q >= IDX_END) begin
            state_d   = ST_RUN;
            ready_d   = 1'b1;
            rst_out_d = '0;
          end else if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_ONE;
            for (int k = 0; k < N_CH; k++) begin
              rst_out_d[k] = rst_out_q[k] & (idx_q != IW'(k));
            end
            // the edge that frees the last channel also enters RUN
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          ready_d = 1'b1;
        end
        default: begin
          state_d   = ST_ASSERT;
          cnt_d     = '0;
          idx_d     = '0;
          rst_out_d = ALL_ONES;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  // state registers with synchronous global reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      db_cnt_q  <= '0;
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= ALL_ONES;
      ready_q   <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      sync_q    <= sync_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      cause_q   <= cause_d;
    end
  end

  assign rst_out = rst_out_q;
  assign ready   = ready_q;
  assign cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: default instance plus a 1-channel, 1-cycle instance,
// both checked against a model based on "edges since the last reset event".
module tb_reset_sequencer;

  localparam int SYNC = 2;
  localparam int DB   = 4;

  logic       clk;
  logic       rst;
  logic       rst_req_async;
  logic       sw_rst;
  logic [2:0] rst_out_a;
  logic       ready_a;
  logic [1:0] cause_a;
  logic [0:0] rst_out_b;
  logic       ready_b;
  logic [1:0] cause_b;

  reset_sequencer #(.N_CH(3), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
                    .HOLD_CYCLES(16), .STAGE_GAP(4)) u_dut (
    .clk(clk), .rst(rst), .rst_req_async(rst_req_async), .sw_rst(sw_rst),
    .rst_out(rst_out_a), .ready(ready_a), .cause(cause_a));

  reset_sequencer #(.N_CH(1), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
                    .HOLD_CYCLES(1), .STAGE_GAP(1)) u_min (
    .clk(clk), .rst(rst), .rst_req_async(rst_req_async), .sw_rst(sw_rst),
    .rst_out(rst_out_b), .ready(ready_b), .cause(cause_b));

  typedef struct packed {
    logic [2:0] ro;
    logic       rdy;
    logic [1:0] cs;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  bit       hist[$];
  int       run_len = 0;
  int       t_since = 0;
  logic [1:0] m_cause = 2'b00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t expect_of(int t, int n, int hold, int gap, logic [1:0] c);
    exp_t e;
    e.ro = 3'b000;
    for (int k = 0; k < n; k++) e.ro[k] = (t < hold + k * gap);
    e.rdy = (t >= hold + (n - 1) * gap);
    e.cs  = c;
    return e;
  endfunction

  // one clock of stimulus; the model advances to the state after the coming edge
  task automatic step(input logic r, input logic a, input logic s);
    bit ra;
    bit rs;
    @(negedge clk);
    rst = r;
    rst_req_async = a;
    sw_rst = s;
    if (r) begin
      hist = {};
      for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
      run_len = 0;
      t_since = 0;
      m_cause = 2'b00;
    end else begin
      ra = (run_len >= DB);
      rs = hist[0];
      void'(hist.pop_front());
      hist.push_back(a);
      run_len = rs ? ((run_len < DB) ? run_len + 1 : run_len) : 0;
      if (ra || s) begin
        t_since = 0;
        m_cause = ra ? 2'b01 : 2'b10;
      end else if (t_since < 100000) begin
        t_since++;
      end
    end
    q_a.push_back(expect_of(t_since, 3, 16, 4, m_cause));
    q_b.push_back(expect_of(t_since, 1, 1, 1, m_cause));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // monitor: compare each presented output against the oldest expectation
  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        g = {rst_out_a, ready_a, cause_a};
        n_cmp++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL main cyc=%0d got rst_out=%b ready=%b cause=%b want rst_out=%b ready=%b cause=%b",
                   cyc, g.ro, g.rdy, g.cs, e.ro, e.rdy, e.cs);
        end
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        g = {2'b00, rst_out_b, ready_b, cause_b};
        n_cmp++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL min cyc=%0d got rst_out=%b ready=%b cause=%b want rst_out=%b ready=%b cause=%b",
                   cyc, g.ro[0], g.rdy, g.cs, e.ro[0], e.rdy, e.cs);
        end
      end
    end
  end

  initial begin
    int   hold_left;
    logic a_lvl;
    rst = 1'b1;
    rst_req_async = 1'b0;
    sw_rst = 1'b0;
    for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);

    // power-up sequence
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    idle(30);
    // short glitch on the external request
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    idle(10);
    // long external request
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
    idle(40);
    // software reset while part-way through release
    step(1'b0, 1'b0, 1'b1);
    idle(18);
    step(1'b0, 1'b0, 1'b1);
    idle(30);
    // software pulse on the cycle the debounced request becomes active
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
    idle(22);
    // global reset mid-release
    step(1'b1, 1'b0, 1'b0);
    idle(30);

    // randomized mix of all three sources
    hold_left = 0;
    a_lvl = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (hold_left == 0) begin
        a_lvl = ($urandom_range(0, 2) == 0);
        hold_left = $urandom_range(1, 25);
      end
      hold_left--;
      step(($urandom_range(0, 399) == 0), a_lvl, ($urandom_range(0, 59) == 0));
    end
    idle(40);

    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
